// File: rtl/clock_pkg.sv
// Shared constants for the clock control stage: mode encodings and the
// register-width helpers used by the prescaler and the key debouncers.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_SET   = 2'd2
    } mode_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The prescaler must span the slower of the two tick rates.
    function automatic int presc_width(input int div, input int fast_div);
        return cnt_width((div > fast_div) ? div : fast_div);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one raw front-panel key: 2-FF synchronizer, stability counter and
// a registered one-cycle pulse on each accepted press (releases are silent).
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values; blocking ones would collapse the sync chain.
            sync_a  <= key_in;
            sync_b  <= sync_a;
            level_d <= level;
            press   <= level & ~level_d;

            // The counter only runs while the synchronized level disagrees
            // with the accepted one; any agreement restarts the window.
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_tick_ctrl.sv
// Upstream control for the clock counter chain: mode FSM, tick prescaler and
// clear pulse generation, driven by two debounced front-panel keys.
module clock_tick_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 1,
    parameter int FAST_HZ      = 16,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_clr,
    output logic       tick,
    output logic       clr,
    output logic [1:0] mode
);

    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int FAST_DIV = CLK_HZ / FAST_HZ;
    localparam int PW       = presc_width(DIV, FAST_DIV);

    localparam logic [PW-1:0] RUN_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

    logic          mode_press;
    logic          clr_press;
    mode_e         state;
    mode_e         state_next;
    logic          counting;
    logic [PW-1:0] presc_last;
    logic [PW-1:0] presc;
    logic          terminal;
    logic          restart;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_mode),
        .press  (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_clr),
        .press  (clr_press)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MODE_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        if (mode_press) begin
            unique case (state)
                MODE_RUN:   state_next = MODE_PAUSE;
                MODE_PAUSE: state_next = MODE_SET;
                MODE_SET:   state_next = MODE_RUN;
                default:    state_next = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        counting   = 1'b0;
        presc_last = RUN_LAST;
        unique case (state)
            MODE_RUN: begin
                counting   = 1'b1;
                presc_last = RUN_LAST;
            end
            MODE_SET: begin
                counting   = 1'b1;
                presc_last = FAST_LAST;
            end
            default: begin
                counting   = 1'b0;
                presc_last = RUN_LAST;
            end
        endcase
    end

    assign mode = state;

    // A mode change or clear restarts the period and swallows a coincident tick.
    assign restart  = mode_press | clr_press;
    assign terminal = counting && (presc == presc_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
            clr   <= 1'b0;
        end else begin
            clr  <= clr_press;
            tick <= terminal & ~restart;
            if (restart || terminal) begin
                presc <= '0;
            end else if (counting) begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Scoreboard bench for clock_tick_ctrl: stimulus queues the expected output
// events (cycle, tick, clr, mode) and a monitor compares each one the DUT shows.
module tb_clock_tick_ctrl;

    typedef struct {
        int         cyc;
        logic       tick;
        logic       clr;
        logic [1:0] mode;
    } ev_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_clr  = 1'b0;
    logic       tick;
    logic       clr;
    logic [1:0] mode;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [1:0] prev_mode;
    ev_t  exp_q[$];

    clock_tick_ctrl #(
        .CLK_HZ       (100),
        .TICK_HZ      (10),
        .FAST_HZ      (50),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_clr  (key_clr),
        .tick     (tick),
        .clr      (clr),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int c, input logic t, input logic cl, input logic [1:0] m);
        ev_t e;
        e.cyc  = c;
        e.tick = t;
        e.clr  = cl;
        e.mode = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Monitor: any tick, clr or mode change is an event that must match the queue head.
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (mon_en && (tick || clr || (mode != prev_mode))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event at cycle %0d: got tick=%0d clr=%0d mode=%0d, expected no event",
                         cyc, tick, clr, mode);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_outputs", {28'd0, tick, clr, mode}, {28'd0, e.tick, e.clr, e.mode});
            end
        end
        prev_mode = mode;
    end

    initial begin
        // Reset held over edges 1..3, released before edge 4.
        wait_cyc(3);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_clr", {31'd0, clr}, 32'd0);
        check("reset_mode", {30'd0, mode}, 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        for (int c = 13; c <= 33; c += 10) expect_ev(c, 1'b1, 1'b0, 2'd0);

        // Three-cycle glitch on the mode key: no press, cadence unchanged.
        wait_cyc(35);
        expect_ev(43, 1'b1, 1'b0, 2'd0);
        expect_ev(53, 1'b1, 1'b0, 2'd0);
        key_mode = 1'b1;
        wait_cyc(38);
        key_mode = 1'b0;

        // Three full mode presses: RUN -> PAUSE -> SET -> RUN.
        wait_cyc(52);
        expect_ev(60, 1'b0, 1'b0, 2'd1);
        expect_ev(88, 1'b0, 1'b0, 2'd2);
        for (int c = 90; c <= 118; c += 2) expect_ev(c, 1'b1, 1'b0, 2'd2);
        expect_ev(119, 1'b0, 1'b0, 2'd0);
        for (int c = 129; c <= 149; c += 10) expect_ev(c, 1'b1, 1'b0, 2'd0);
        key_mode = 1'b1;
        wait_cyc(72);
        key_mode = 1'b0;
        wait_cyc(80);
        key_mode = 1'b1;
        wait_cyc(100);
        key_mode = 1'b0;
        wait_cyc(111);
        key_mode = 1'b1;
        wait_cyc(131);
        key_mode = 1'b0;

        // Clear lands while the prescaler holds 7; next tick a full period later.
        wait_cyc(149);
        expect_ev(157, 1'b0, 1'b1, 2'd0);
        for (int c = 167; c <= 187; c += 10) expect_ev(c, 1'b1, 1'b0, 2'd0);
        key_clr = 1'b1;
        wait_cyc(159);
        key_clr = 1'b0;

        // Both keys together, landing on the terminal count: tick suppressed.
        wait_cyc(189);
        expect_ev(197, 1'b0, 1'b1, 2'd1);
        key_clr  = 1'b1;
        key_mode = 1'b1;
        wait_cyc(199);
        key_clr  = 1'b0;
        key_mode = 1'b0;

        // Into SET, then a one-cycle reset in the middle of a debounce window.
        wait_cyc(210);
        expect_ev(218, 1'b0, 1'b0, 2'd2);
        for (int c = 220; c <= 232; c += 2) expect_ev(c, 1'b1, 1'b0, 2'd2);
        expect_ev(234, 1'b0, 1'b0, 2'd0);
        key_mode = 1'b1;
        wait_cyc(220);
        key_mode = 1'b0;
        wait_cyc(230);
        key_mode = 1'b1;
        wait_cyc(233);
        rst_n = 1'b0;
        wait_cyc(234);
        rst_n    = 1'b1;
        key_mode = 1'b0;
        check("midreset_tick", {31'd0, tick}, 32'd0);
        check("midreset_clr", {31'd0, clr}, 32'd0);
        check("midreset_mode", {30'd0, mode}, 32'd0);
        for (int c = 244; c <= 264; c += 10) expect_ev(c, 1'b1, 1'b0, 2'd0);
        expect_ev(268, 1'b0, 1'b0, 2'd1);

        // Key held for 30 cycles: exactly one press.
        wait_cyc(260);
        key_mode = 1'b1;
        wait_cyc(290);
        key_mode = 1'b0;

        wait_cyc(300);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
